// File: rtl/fifo_word_packer.sv
// Drains WIDTH-bit words from a synchronous FIFO and packs RATIO of them into one wide beat
// on a valid/ready stream; flush closes a partial beat and marks it last.
module fifo_word_packer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned RATIO = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   output logic                   fifo_rd_en,
   input  logic [WIDTH-1:0]       fifo_dout,
   input  logic                   flush,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [WIDTH*RATIO-1:0] m_data,
   output logic [RATIO-1:0]       m_mask,
   output logic                   m_last,
   output logic                   busy
);

   localparam int unsigned CNT_W = $clog2(RATIO + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(RATIO);

   logic [WIDTH*RATIO-1:0] acc_q, acc_d, acc_arr;
   logic [CNT_W-1:0]       count_q, count_d, cnt_arr;
   logic                   inflight_q;
   logic                   flush_pending_q, flush_pending_d;
   logic                   m_valid_q, m_valid_d;
   logic [WIDTH*RATIO-1:0] m_data_q, m_data_d;
   logic [RATIO-1:0]       m_mask_q, m_mask_d, mask_arr;
   logic                   m_last_q, m_last_d;
   logic                   flush_eff, out_free, beat_done, load, empty_flush;

   always_comb begin
      // A flush arriving this cycle applies to a beat loading this cycle.
      flush_eff = flush_pending_q | flush;
      cnt_arr   = count_q + CNT_W'(inflight_q);

      acc_arr  = acc_q;
      mask_arr = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (inflight_q && (count_q == CNT_W'(k))) begin
            acc_arr[k*WIDTH +: WIDTH] = fifo_dout;
         end
         mask_arr[k] = (CNT_W'(k) < cnt_arr);
      end

      // Extra bit: count + inflight may reach RATIO+1 bits of range.
      fifo_rd_en = !fifo_empty && !flush_pending_q &&
                   ((CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) < (CNT_W+1)'(RATIO));

      out_free    = !m_valid_q || m_ready;
      beat_done   = (cnt_arr == FULL) || (flush_eff && !inflight_q && (count_q != '0));
      load        = out_free && beat_done;
      empty_flush = flush_eff && !inflight_q && (count_q == '0);

      acc_d           = acc_arr;
      count_d         = cnt_arr;
      flush_pending_d = flush_eff;
      m_valid_d       = m_valid_q && !m_ready;
      m_data_d        = m_data_q;
      m_mask_d        = m_mask_q;
      m_last_d        = m_last_q;

      if (load) begin
         acc_d           = '0;
         count_d         = '0;
         flush_pending_d = 1'b0;
         m_valid_d       = 1'b1;
         m_data_d        = acc_arr;
         m_mask_d        = mask_arr;
         m_last_d        = flush_eff;
      end else if (empty_flush) begin
         flush_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q           <= '0;
         count_q         <= '0;
         inflight_q      <= 1'b0;
         flush_pending_q <= 1'b0;
         m_valid_q       <= 1'b0;
         m_data_q        <= '0;
         m_mask_q        <= '0;
         m_last_q        <= 1'b0;
      end else begin
         acc_q           <= acc_d;
         count_q         <= count_d;
         inflight_q      <= fifo_rd_en;
         flush_pending_q <= flush_pending_d;
         m_valid_q       <= m_valid_d;
         m_data_q        <= m_data_d;
         m_mask_q        <= m_mask_d;
         m_last_q        <= m_last_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_mask  = m_mask_q;
   assign m_last  = m_last_q;
   assign busy    = (count_q != '0) || inflight_q || m_valid_q || flush_pending_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (WIDTH=4, RATIO=4) with a one-cycle-latency FIFO model.
module tb_fifo_word_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [3:0]  fifo_dout;
   logic        flush;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic [3:0]  m_mask;
   logic        m_last;
   logic        busy;

   fifo_word_packer #(.WIDTH(4), .RATIO(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_mask     (m_mask),
      .m_last     (m_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // FIFO model: read data appears the cycle after the accepted read.
   logic [3:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int rd_count = 0;
   int rd_empty_viol = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
         fifo_dout <= mem[rd_ptr[5:0]];
         rd_ptr    <= rd_ptr + 1;
         rd_count  <= rd_count + 1;
      end
   end

   task automatic push(input logic [3:0] w);
      mem[wr_ptr[5:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   // Beat collector and protocol monitors.
   logic [15:0] bq_data [$];
   logic [3:0]  bq_mask [$];
   logic        bq_last [$];
   int          stab_viol = 0;
   int          loss_viol = 0;
   int          valid_cycles = 0;
   logic        prev_hold = 1'b0;
   logic [20:0] prev_out = '0;

   always @(posedge clk) begin
      if (!rst && m_valid && m_ready) begin
         bq_data.push_back(m_data);
         bq_mask.push_back(m_mask);
         bq_last.push_back(m_last);
      end
      if (!rst && prev_hold && ({m_data, m_mask, m_last} != prev_out)) stab_viol <= stab_viol + 1;
      prev_hold <= m_valid && !m_ready && !rst;
      prev_out  <= {m_data, m_mask, m_last};
      if (m_valid) valid_cycles <= valid_cycles + 1;
      // A word landing on a full accumulator would be lost.
      if (!rst && dut.inflight_q && (dut.count_q == 3'd4)) loss_viol <= loss_viol + 1;
   end

   task automatic clear_beats();
      bq_data.delete();
      bq_mask.delete();
      bq_last.delete();
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int i = 0; i < budget && bq_data.size() < n; i++) @(negedge clk);
   endtask

   int rd_base;
   int v_base;

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      check("rst_mask", 32'(m_mask), 32'd0);
      check("rst_last", 32'(m_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

      // Two full beats streaming through.
      m_ready = 1'b1;
      rd_base = rd_count;
      clear_beats();
      for (int i = 1; i <= 8; i++) push(4'(i));
      wait_beats(2, 40);
      repeat (3) @(negedge clk);
      check("t1_beats", 32'(bq_data.size()), 32'd2);
      if (bq_data.size() >= 2) begin
         check("t1_data0", 32'(bq_data[0]), 32'h4321);
         check("t1_data1", 32'(bq_data[1]), 32'h8765);
         check("t1_mask0", 32'(bq_mask[0]), 32'hF);
         check("t1_mask1", 32'(bq_mask[1]), 32'hF);
         check("t1_last0", 32'(bq_last[0]), 32'd0);
         check("t1_last1", 32'(bq_last[1]), 32'd0);
      end
      check("t1_reads", 32'(rd_count - rd_base), 32'd8);
      check("t1_busy", 32'(busy), 32'd0);

      // Partial beat closed by flush.
      clear_beats();
      push(4'hA);
      push(4'hB);
      push(4'hC);
      repeat (6) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_beats(1, 20);
      repeat (2) @(negedge clk);
      check("t2_beats", 32'(bq_data.size()), 32'd1);
      if (bq_data.size() >= 1) begin
         check("t2_data", 32'(bq_data[0]), 32'h0CBA);
         check("t2_mask", 32'(bq_mask[0]), 32'b0111);
         check("t2_last", 32'(bq_last[0]), 32'd1);
      end
      check("t2_busy", 32'(busy), 32'd0);

      // Backpressure: one beat held, one beat stalled in the accumulator.
      m_ready = 1'b0;
      rd_base = rd_count;
      clear_beats();
      for (int i = 0; i < 16; i++) push(4'(i));
      repeat (30) @(negedge clk);
      check("t3_hold_reads", 32'(rd_count - rd_base), 32'd8);
      check("t3_hold_rd_en", 32'(fifo_rd_en), 32'd0);
      check("t3_hold_valid", 32'(m_valid), 32'd1);
      check("t3_hold_data", 32'(m_data), 32'h3210);
      check("t3_hold_busy", 32'(busy), 32'd1);
      m_ready = 1'b1;
      wait_beats(4, 60);
      repeat (3) @(negedge clk);
      check("t3_beats", 32'(bq_data.size()), 32'd4);
      if (bq_data.size() >= 4) begin
         check("t3_data0", 32'(bq_data[0]), 32'h3210);
         check("t3_data1", 32'(bq_data[1]), 32'h7654);
         check("t3_data2", 32'(bq_data[2]), 32'hBA98);
         check("t3_data3", 32'(bq_data[3]), 32'hFEDC);
      end
      check("t3_reads", 32'(rd_count - rd_base), 32'd16);

      // Flush with nothing accumulated: no beat.
      v_base = valid_cycles;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (2) @(negedge clk);
      check("t4_no_valid", 32'(valid_cycles - v_base), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);

      // Reset mid-beat.
      clear_beats();
      push(4'h1);
      push(4'h2);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_valid", 32'(m_valid), 32'd0);
      check("t5_data", 32'(m_data), 32'd0);
      check("t5_mask", 32'(m_mask), 32'd0);
      check("t5_last", 32'(m_last), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      push(4'h9);
      push(4'hA);
      push(4'hB);
      push(4'hC);
      wait_beats(1, 20);
      check("t5_beats", 32'(bq_data.size()), 32'd1);
      if (bq_data.size() >= 1) check("t5_data_new", 32'(bq_data[0]), 32'hCBA9);
      repeat (3) @(negedge clk);

      // Flush in the cycle the 4th word lands.
      clear_beats();
      for (int i = 1; i <= 8; i++) push(4'(i));
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_beats(2, 40);
      check("t6_beats", 32'(bq_data.size()), 32'd2);
      if (bq_data.size() >= 2) begin
         check("t6_data0", 32'(bq_data[0]), 32'h4321);
         check("t6_mask0", 32'(bq_mask[0]), 32'hF);
         check("t6_last0", 32'(bq_last[0]), 32'd1);
         check("t6_data1", 32'(bq_data[1]), 32'h8765);
         check("t6_last1", 32'(bq_last[1]), 32'd0);
      end
      repeat (3) @(negedge clk);

      check("no_loss", 32'(loss_viol), 32'd0);
      check("no_rd_empty", 32'(rd_empty_viol), 32'd0);
      check("stable_hold", 32'(stab_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the team's synchronous FIFO.
- Drains narrow WIDTH-bit words through the FIFO read port and packs RATIO consecutive words into one wide beat.
- Presents each beat on a valid/ready master stream, for example toward a wide memory writer.
- A flush input closes a partially filled beat and marks it last.

Parameters:
- WIDTH, 4, width of one FIFO word.
- RATIO, 4, words per output beat; legal range 2 to 16.
- CNT_W, $clog2(RATIO+1), local; width of the word counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read request; combinational.
- fifo_dout  in  WIDTH  FIFO read data; valid the cycle after an accepted read.
- flush  in  1  single-cycle request to close the current beat.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  WIDTH*RATIO  packed beat.
- m_mask  out  RATIO  per-lane valid mask.
- m_last  out  1  beat was closed by flush.
- busy  out  1  block holds or expects data.

Behaviour:
- Clocking and reset:
  - Clock clk; reset rst, synchronous, active-high.
  - On reset, clear: m_valid, m_data, m_mask, m_last, busy, the accumulator and its word count, the in-flight flag, and flush_pending.
  - Reset mid-operation discards accumulated and in-flight words without error.
- Upstream contract:
  - A read is issued in cycle t when fifo_rd_en=1.
  - fifo_dout is captured at the end of cycle t+1. The in-flight register is 1 bit.
- Read issue:
  - fifo_rd_en = !fifo_empty && !flush_pending && (count + inflight < RATIO).
  - Never assert fifo_rd_en while fifo_empty=1.
- Lane order:
  - The k-th word of a beat (k=0..RATIO-1) lands in m_data[k*WIDTH +: WIDTH]; the first word read goes to lane 0.
  - Unused lanes of a partial beat are driven 0.
- Beat completion:
  - A beat completes when the arriving word brings count to RATIO, or when flush_pending is set and inflight=0.
  - If the output register is empty, or is being accepted this cycle (m_valid && m_ready), the completed beat loads into the output register that cycle and count returns to 0.
  - Otherwise the accumulator holds the full beat (count=RATIO) and reads stall.
- Throughput: sustained rate is RATIO words per RATIO+1 cycles, i.e. one issue bubble per beat.
- Output handshake:
  - m_data, m_mask and m_last must stay stable while m_valid && !m_ready.
  - m_valid drops the cycle after acceptance unless a new beat loads in that same cycle.
- Mask: all ones for a full beat; the low `count` bits set for a flushed partial beat.
- Flush:
  - flush sets flush_pending. flush while flush_pending=1 is ignored.
  - While pending, no new reads are issued and the in-flight word is allowed to land.
  - The next beat loaded into the output register, full or partial, has m_last=1; loading it clears flush_pending.
  - If count=0 and inflight=0 when draining completes, no beat is emitted and flush_pending clears.
  - A flush sampled in the same cycle a beat loads applies to that beat.
- busy = (count!=0) || inflight || m_valid || flush_pending.
- Data-loss contract: a word that arrives with the accumulator stalled full cannot occur by construction. The bench must assert this.

Test Plan:
- 8 words 1..8 queued, m_ready=1, WIDTH=4, RATIO=4 -> beats m_data=16'h4321 then 16'h8765, m_mask=4'hF, m_last=0, 8 reads total.
- 3 words A,B,C then flush pulse -> one beat m_data=16'h0CBA, m_mask=4'b0111, m_last=1; busy=0 afterwards.
- 16 words queued, m_ready=0 -> one beat held stable, accumulator full, exactly 8 reads issued, fifo_rd_en=0 thereafter; raising m_ready yields 4 in-order beats with no loss.
- Flush with count=0 and no read in flight -> no m_valid pulse; busy clears within 2 cycles.
- rst after 2 words of a beat -> all outputs 0 the next cycle; the first post-reset FIFO word appears in lane 0 of the next beat.
- Flush in the same cycle the 4th word lands -> beat m_mask=4'hF, m_last=1; the following beat has m_last=0.
